mux4to1_rr_stream: RTL and testbench

- Four-channel packet merger: the combining counterpart of the 1-to-4 demultiplexer. Merges four valid/ready input streams onto one registered output stream.
- Tags each output beat with its source channel on YSel, so a downstream 1-to-4 demux can split the traffic back out.
- Round-robin arbitration with packet locking: once a channel wins, it keeps the output until its Last beat.
- Sits between channel producers and a shared link or serializer.

---
 rtl/mux4to1_rr_stream_if.sv | 27 ++
 rtl/mux4to1_rr_stream.sv | 149 ++++++++++++++
 tb/tb_mux4to1_rr_stream.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mux4to1_rr_stream_if.sv
// Stream bundle for the four-channel round-robin merger: four input
// valid/ready channels plus one tagged output channel.
interface mux4to1_rr_stream_if #(
    parameter int WIDTH = 8
);
    logic [4*WIDTH-1:0] InData;
    logic [3:0]         InValid;
    logic [3:0]         InLast;
    logic [3:0]         InReady;
    logic [WIDTH-1:0]   Y;
    logic               YLast;
    logic [1:0]         YSel;
    logic               YValid;
    logic               YReady;

    // Producer/consumer side: drives the channels and accepts the merged stream
    modport master (
        output InData, InValid, InLast, YReady,
        input  InReady, Y, YLast, YSel, YValid
    );

    // Merger side
    modport slave (
        input  InData, InValid, InLast, YReady,
        output InReady, Y, YLast, YSel, YValid
    );
endinterface

// File: rtl/mux4to1_rr_stream.sv
// Four-channel packet merger. Round-robin arbitration between packets;
// the winning channel owns the registered output until its last beat.
// Each output beat carries its source channel index on YSel.
module mux4to1_rr_stream #(
    parameter int WIDTH = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    mux4to1_rr_stream_if.slave    bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       owner_q, owner_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             ylast_q, ylast_d;
    logic [1:0]       ysel_q, ysel_d;
    logic             yvalid_q, yvalid_d;

    logic [WIDTH-1:0] ch_data [4];
    logic             load;
    logic             grant_valid;
    logic [1:0]       grant_idx;
    logic [3:0]       in_ready;
    logic [1:0]       xfer_idx;
    logic             xfer;
    logic             xfer_last;

    // Split the packed input bus into per-channel words
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chan
            assign ch_data[gi] = bus.InData[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Output register can take a beat when empty or being drained this cycle
    assign load = ~yvalid_q | bus.YReady;

    // Round-robin search starting at the pointer
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            if (!grant_valid && bus.InValid[ptr_q + 2'(k)]) begin
                grant_valid = 1'b1;
                grant_idx   = ptr_q + 2'(k);
            end
        end
    end

    // Per-channel ready: arbitration winner in IDLE, packet owner in LOCKED
    always_comb begin
        in_ready = 4'b0000;
        xfer_idx = owner_q;
        if (!Rst) begin
            case (state_q)
                IDLE: begin
                    xfer_idx = grant_idx;
                    if (load && grant_valid) begin
                        in_ready[grant_idx] = 1'b1;
                    end
                end
                LOCKED: begin
                    in_ready[owner_q] = load;
                end
                default: in_ready = 4'b0000;
            endcase
        end
    end

    assign xfer        = |(bus.InValid & in_ready);
    assign xfer_last   = bus.InLast[xfer_idx];
    assign bus.InReady = in_ready;

    // Next-state for the arbiter FSM, pointer, owner and output register
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        y_d      = y_q;
        ylast_d  = ylast_q;
        ysel_d   = ysel_q;
        yvalid_d = yvalid_q;

        if (xfer) begin
            y_d      = ch_data[xfer_idx];
            ylast_d  = xfer_last;
            ysel_d   = xfer_idx;
            yvalid_d = 1'b1;
        end else if (load) begin
            // Old beat consumed (or none held) and nothing new: go empty,
            // keep the data fields as they were
            yvalid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (xfer_last) begin
                        ptr_d = xfer_idx + 2'd1;
                    end else begin
                        owner_d = xfer_idx;
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                // Pointer frozen while a packet is in flight
                if (xfer && xfer_last) begin
                    ptr_d   = owner_q + 2'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset drops any lock and any held beat
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            ptr_q    <= 2'd0;
            owner_q  <= 2'd0;
            y_q      <= '0;
            ylast_q  <= 1'b0;
            ysel_q   <= 2'd0;
            yvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            y_q      <= y_d;
            ylast_q  <= ylast_d;
            ysel_q   <= ysel_d;
            yvalid_q <= yvalid_d;
        end
    end

    assign bus.Y      = y_q;
    assign bus.YLast  = ylast_q;
    assign bus.YSel   = ysel_q;
    assign bus.YValid = yvalid_q;

endmodule

// File: tb/tb_mux4to1_rr_stream.sv
// Directed bench for the four-channel round-robin merger.
module tb_mux4to1_rr_stream;

    localparam int WIDTH = 8;

    logic Clk;
    logic Rst;
    logic [WIDTH-1:0] d [4];

    int n_checks;
    int n_fail;
    int cycle;

    mux4to1_rr_stream_if #(.WIDTH(WIDTH)) bus ();

    assign bus.InData = {d[3], d[2], d[1], d[0]};

    mux4to1_rr_stream #(.WIDTH(WIDTH)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // Advance one clock, sample 1 time unit after the edge, log the output beat
    task automatic step();
        @(posedge Clk);
        #1;
        cycle++;
        $display("cyc %0d: YValid=%0b Y=%02h YSel=%0d YLast=%0b InReady=%04b",
                 cycle, bus.YValid, bus.Y, bus.YSel, bus.YLast, bus.InReady);
    endtask

    task automatic check_out(input string tag, input logic [7:0] y, input logic [1:0] sel,
                             input logic last, input logic vld);
        check({tag, ".YValid"}, 32'(bus.YValid), 32'(vld));
        check({tag, ".Y"},      32'(bus.Y),      32'(y));
        check({tag, ".YSel"},   32'(bus.YSel),   32'(sel));
        check({tag, ".YLast"},  32'(bus.YLast),  32'(last));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cycle    = 0;
        Rst = 1'b1;
        bus.InValid = 4'b0000;
        bus.InLast  = 4'b0000;
        bus.YReady  = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = 8'h00;

        // Reset, with requests present to prove InReady stays low
        bus.InValid = 4'b1111;
        step();
        step();
        check_out("reset", 8'h00, 2'd0, 1'b0, 1'b0);
        check("reset.InReady", 32'(bus.InReady), 32'h0);

        // Release with nothing valid: output stays empty
        bus.InValid = 4'b0000;
        Rst = 1'b0;
        bus.YReady = 1'b1;
        step();
        step();
        check("idle.YValid", 32'(bus.YValid), 32'h0);
        check("idle.InReady", 32'(bus.InReady), 32'h0);

        // Single-beat rotation, one beat per cycle
        for (int i = 0; i < 4; i++) d[i] = 8'hA0 + 8'(i);
        bus.InLast  = 4'b1111;
        bus.InValid = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("rot.InReady", 32'(bus.InReady), 32'(4'b0001 << (k % 4)));
            step();
            check_out("rot", 8'hA0 + 8'(k % 4), 2'(k % 4), 1'b1, 1'b1);
        end
        bus.InValid = 4'b0000;
        step();
        check("rot.drain.YValid", 32'(bus.YValid), 32'h0);
        check("rot.drain.Yhold", 32'(bus.Y), 32'hA0);
        // Ptr now 1

        // Packet lock: ch2 three beats while ch0 waits
        d[0] = 8'hC0;
        d[2] = 8'h11;
        bus.InLast  = 4'b0001;
        bus.InValid = 4'b0101;
        #1;
        check("lock.InReady1", 32'(bus.InReady), 32'b0100);
        step();
        check_out("lock.b1", 8'h11, 2'd2, 1'b0, 1'b1);
        d[2] = 8'h22;
        #1;
        check("lock.InReady2", 32'(bus.InReady), 32'b0100);
        step();
        check_out("lock.b2", 8'h22, 2'd2, 1'b0, 1'b1);
        d[2] = 8'h33;
        bus.InLast = 4'b0101;
        #1;
        check("lock.InReady3", 32'(bus.InReady), 32'b0100);
        step();
        check_out("lock.b3", 8'h33, 2'd2, 1'b1, 1'b1);
        bus.InValid = 4'b0001;
        #1;
        check("lock.InReady.ch0", 32'(bus.InReady), 32'b0001);
        step();
        check_out("lock.ch0", 8'hC0, 2'd0, 1'b1, 1'b1);
        bus.InValid = 4'b0000;
        step();
        check("lock.drain.YValid", 32'(bus.YValid), 32'h0);
        // Ptr now 1

        // Backpressure with 5C held
        d[1] = 8'h5C;
        bus.InLast  = 4'b1111;
        bus.InValid = 4'b0010;
        bus.YReady  = 1'b0;
        #1;
        check("bp.InReady.load", 32'(bus.InReady), 32'b0010);
        step();
        check_out("bp.load", 8'h5C, 2'd1, 1'b1, 1'b1);
        d[1] = 8'h6D;
        for (int k = 0; k < 4; k++) begin
            check("bp.InReady.stall", 32'(bus.InReady), 32'h0);
            step();
            check_out("bp.hold", 8'h5C, 2'd1, 1'b1, 1'b1);
        end
        bus.YReady = 1'b1;
        #1;
        check("bp.InReady.release", 32'(bus.InReady), 32'b0010);
        step();
        check_out("bp.next", 8'h6D, 2'd1, 1'b1, 1'b1);
        bus.InValid = 4'b0000;
        step();
        check("bp.drain.YValid", 32'(bus.YValid), 32'h0);
        // Ptr now 2

        // Pointer fairness: ch2 grant moves Ptr to 3
        d[0] = 8'h0F;
        d[2] = 8'h22;
        d[3] = 8'h33;
        bus.InValid = 4'b0100;
        step();
        check_out("fair.ch2", 8'h22, 2'd2, 1'b1, 1'b1);
        bus.InValid = 4'b1001;
        #1;
        check("fair.InReady.ch3", 32'(bus.InReady), 32'b1000);
        step();
        check_out("fair.ch3", 8'h33, 2'd3, 1'b1, 1'b1);
        check("fair.InReady.ch0", 32'(bus.InReady), 32'b0001);
        step();
        check_out("fair.ch0", 8'h0F, 2'd0, 1'b1, 1'b1);
        bus.InValid = 4'b0000;
        step();
        // Ptr now 1

        // Reset mid-packet of a 4-beat ch1 packet
        d[1] = 8'h41;
        bus.InLast  = 4'b0000;
        bus.InValid = 4'b0010;
        step();
        check_out("mid.b1", 8'h41, 2'd1, 1'b0, 1'b1);
        d[1] = 8'h42;
        step();
        check_out("mid.b2", 8'h42, 2'd1, 1'b0, 1'b1);
        Rst = 1'b1;
        #1;
        check("mid.InReady.rst", 32'(bus.InReady), 32'h0);
        step();
        check_out("mid.reset", 8'h00, 2'd0, 1'b0, 1'b0);
        Rst = 1'b0;
        d[0] = 8'h90;
        d[1] = 8'h43;
        bus.InLast  = 4'b0011;
        bus.InValid = 4'b0011;
        #1;
        check("mid.InReady.after", 32'(bus.InReady), 32'b0001);
        step();
        check_out("mid.ch0", 8'h90, 2'd0, 1'b1, 1'b1);
        bus.InValid = 4'b0000;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
